lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store controller directly downstream of the execute stage's AGU load/store port.
- Accepts one memory request per handshake from execute and issues it on a single-outstanding command/response memory bus.
- Returns the raw 32-bit read word plus a completion pulse and an error flag.
- Byte lane selection and sign extension stay upstream in the AGU; this block passes words and byte-enables unchanged.

Parameters:
- TIMEOUT, 255: cycles spent in CMD+RSP before the transaction is aborted with error.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- hs_ex4ls_val  in  1  request valid from execute; held with operands stable until hs_ls4ex_rdy.
- hs_ls4ex_rdy  out  1  one-cycle completion pulse to execute.
- i_ls_adr  in  32  byte address.
- i_ls_wdat  in  32  write data.
- i_ls_wen  in  4  byte write enables; nonzero means store.
- i_ls_ren  in  1  load request.
- o_ls_rdat  out  32  read data; valid while hs_ls4ex_rdy=1.
- o_ls_err  out  1  bus error or timeout; valid while hs_ls4ex_rdy=1.
- o_mem_cmd_val  out  1  bus command valid.
- i_mem_cmd_rdy  in  1  bus command accepted.
- o_mem_adr  out  32  command address.
- o_mem_wdat  out  32  command write data.
- o_mem_wen  out  4  command byte enables.
- o_mem_ren  out  1  command is a read.
- i_mem_rsp_val  in  1  bus response valid; single-cycle pulse.
- i_mem_rsp_dat  in  32  response read data.
- i_mem_rsp_err  in  1  response error.

Behaviour:
- States: IDLE, CMD, RSP, DONE. Reset → IDLE. All outputs reset to 0, as do the captured request registers, rdat/err registers and counter.
- IDLE:
  - Request (val=1 with wen!=0 or ren=1): capture adr/wdat/wen/ren, clear counter, go to CMD.
  - Null request (val=1, wen=0, ren=0): go to DONE with rdat=0, err=0 and no bus access.
  - Both wen!=0 and ren=1: treated as a store; o_mem_ren=0.
- CMD:
  - o_mem_cmd_val=1 and bus fields driven from the captured registers, never combinationally from i_ls_*.
  - cmd_rdy=1 → go to RSP, clear counter.
  - Otherwise increment counter; counter==TIMEOUT → go to DONE with err=1, rdat=0, cmd_val dropped.
- RSP:
  - cmd_val=0. rsp_val=1 → capture rsp_dat into rdat. For a store, rdat=0. Capture rsp_err into err, go to DONE.
  - Otherwise increment counter; timeout handling as in CMD.
- DONE: hs_ls4ex_rdy=1, o_ls_rdat/o_ls_err from registers for exactly one cycle, then go to IDLE.
  - Execute drops or changes val the cycle after rdy, so IDLE accepts a new request on the following edge.
- Latency:
  - Zero-wait bus: val@0 → cmd_val@1 (cmd_rdy=1) → rsp_val@2 → rdy@3.
  - Null request: rdy@1.
- Stray response: rsp_val in IDLE, CMD or DONE (late response after a timeout, or a spurious one) is ignored. It never alters rdat/err and never produces rdy.
- rsp_val in the same cycle that cmd_rdy is accepted in CMD is not a valid response and is ignored.
- Counter saturates at TIMEOUT; it never wraps.
- Reset mid-transaction: return immediately to IDLE, cmd_val=0, rdy=0; any pending bus response is dropped as a stray.
- val=0 while in CMD/RSP is a protocol violation. The transaction completes regardless.

Test Plan:
- Load, zero-wait bus: adr=0x8000_0010, ren=1, rsp_dat=0xDEAD_BEEF → cmd_val@1 with adr 0x8000_0010, ren=1; rdy@3 with rdat=0xDEAD_BEEF, err=0.
- Store with backpressure: wen=4'b0011, wdat=0x1234_5678, cmd_rdy low 5 cycles → cmd_val high 6 cycles with stable fields; rdy 1 cycle after rsp_val; rdat=0, err=0.
- Bus error: load with rsp_err=1 → rdy pulse with err=1; next load (no error) completes with err=0.
- Timeout: TIMEOUT=4, cmd_rdy stuck 0 → rdy after 4 counting cycles in CMD, err=1, cmd_val=0. Later rsp_val=1 in IDLE → no rdy.
- Null request: val=1, wen=0, ren=0 → rdy@1, no cmd_val ever asserted.
- Async reset: assert rst in RSP → outputs 0 immediately; after release a new load completes normally; a late rsp_val is ignored.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store controller: takes one request from execute and runs it on a single-outstanding
// command/response bus, returning the raw read word, an error flag and a one-cycle completion pulse.
module lsu_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ex4ls_val,
    output logic        hs_ls4ex_rdy,
    input  logic [31:0] i_ls_adr,
    input  logic [31:0] i_ls_wdat,
    input  logic [3:0]  i_ls_wen,
    input  logic        i_ls_ren,
    output logic [31:0] o_ls_rdat,
    output logic        o_ls_err,
    output logic        o_mem_cmd_val,
    input  logic        i_mem_cmd_rdy,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_wdat,
    output logic [3:0]  o_mem_wen,
    output logic        o_mem_ren,
    input  logic        i_mem_rsp_val,
    input  logic [31:0] i_mem_rsp_dat,
    input  logic        i_mem_rsp_err
);
    typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_C = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [31:0]      adr_q, wdat_q, rdat_q, rdat_nxt;
    logic [3:0]       wen_q;
    logic             ren_q, err_q, err_nxt, cap;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             cnt_hit;

    // Saturating increment; the cycle whose increment reaches TIMEOUT is the last one waited.
    assign cnt_inc = (cnt == TO_C) ? cnt : cnt + CNT_W'(1);
    assign cnt_hit = (cnt_inc == TO_C);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdat_nxt  = rdat_q;
        err_nxt   = err_q;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (hs_ex4ls_val) begin
                    if (i_ls_wen != 4'd0 || i_ls_ren) begin
                        cap       = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = CMD;
                    end else begin
                        rdat_nxt  = '0;
                        err_nxt   = 1'b0;
                        state_nxt = DONE;
                    end
                end
            end
            CMD: begin
                if (i_mem_cmd_rdy) begin
                    cnt_nxt   = '0;
                    state_nxt = RSP;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_hit) begin
                        rdat_nxt  = '0;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            RSP: begin
                if (i_mem_rsp_val) begin
                    rdat_nxt  = (wen_q != 4'd0) ? 32'd0 : i_mem_rsp_dat;
                    err_nxt   = i_mem_rsp_err;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_hit) begin
                        rdat_nxt  = '0;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            adr_q  <= '0;
            wdat_q <= '0;
            wen_q  <= '0;
            ren_q  <= 1'b0;
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rdat_q <= rdat_nxt;
            err_q  <= err_nxt;
            if (cap) begin
                adr_q  <= i_ls_adr;
                wdat_q <= i_ls_wdat;
                wen_q  <= i_ls_wen;
                // A request with both enables set is a store.
                ren_q  <= i_ls_ren && (i_ls_wen == 4'd0);
            end
        end
    end

    assign hs_ls4ex_rdy  = (state == DONE);
    assign o_mem_cmd_val = (state == CMD);
    assign o_ls_rdat     = rdat_q;
    assign o_ls_err      = err_q;
    assign o_mem_adr     = adr_q;
    assign o_mem_wdat    = wdat_q;
    assign o_mem_wen     = wen_q;
    assign o_mem_ren     = ren_q;
endmodule
